patch_en_gen: RTL

Parametrised per-lane enable generator for the convolution processor array. It produces an N_PE-bit lane-enable mask for every input beat. A lane is enabled when its column completes a patch window for the programmed patch size and stride, in both the horizontal and vertical directions. Masks are computed arithmetically, with no per-configuration lookup, for any patch/stride combination and image size. A registered copy of each mask is forwarded to the RMU, gated off once the RMU reports done.

---
 rtl/patch_en_gen.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/patch_en_gen.sv
// -----------------------------------------------------------------------------
// patch_en_gen
//
// Per-lane enable generator for the convolution processor array. Every input
// beat carries N_PE new image columns; for each beat the block produces an
// N_PE-bit mask whose bit i is set when lane i's column completes a patch
// window, both horizontally and vertically, for the programmed patch size P and
// stride S. The mask is computed arithmetically (no lookup tables, no
// dividers), so any legal P/S/W/H combination works.
//
// A registered copy of the mask (p_en_rmu) trails p_en by one cycle and is held
// at zero once the RMU has reported done, until the next accepted start.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : pulse, latch cfg_* and begin a frame (only honoured in IDLE)
//   cfg_patch_size  : patch size P
//   cfg_stride      : stride S
//   cfg_row_len     : columns per row W
//   cfg_num_rows    : rows per frame H
//   cycle_detect    : beat strobe, one beat = N_PE new columns
//   done            : RMU finished; sticky-gates p_en_rmu
//   p_en            : lane mask of the most recent beat (bit i = lane i)
//   p_en_valid      : one-cycle pulse, p_en holds a fresh beat's mask
//   p_en_rmu        : p_en delayed one cycle, forced to 0 after done
//   busy            : high while a frame is running (this is the FSM state)
//   frame_done      : one-cycle pulse together with the last mask of a frame
//   cfg_err         : set by a rejected start, cleared by an accepted start
//
// Handshake: there is no back-pressure. cycle_detect is a strobe that is
// consumed on every rising edge where it is high while busy; the matching
// p_en/p_en_valid appear exactly one cycle later, and consecutive strobes give
// consecutive masks at full rate.
// -----------------------------------------------------------------------------
module patch_en_gen #(
  parameter int N_PE = 8,
  parameter int PW   = 3,
  parameter int LW   = 10,
  parameter int RW   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PW-1:0]   cfg_patch_size,
  input  logic [PW-1:0]   cfg_stride,
  input  logic [LW-1:0]   cfg_row_len,
  input  logic [RW-1:0]   cfg_num_rows,
  input  logic            cycle_detect,
  input  logic            done,
  output logic [N_PE-1:0] p_en,
  output logic            p_en_valid,
  output logic [N_PE-1:0] p_en_rmu,
  output logic            busy,
  output logic            frame_done,
  output logic            cfg_err
);

  // next_off must hold values up to (N_PE-1)+(2^PW-1) during the update walk.
  localparam int LOG_N = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int NW    = ((PW > LOG_N) ? PW : LOG_N) + 1;
  localparam int CW    = LW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]      state_q,      state_d;
  logic [PW-1:0]   p_q,          p_d;
  logic [PW-1:0]   s_q,          s_d;
  logic [LW-1:0]   w_q,          w_d;
  logic [RW-1:0]   h_q,          h_d;
  logic [CW-1:0]   col_base_q,   col_base_d;
  logic [RW-1:0]   row_q,        row_d;
  logic [NW-1:0]   next_off_q,   next_off_d;
  // Rows since the first window-complete row, modulo S. Zero marks an
  // on-stride row, which avoids computing (row-(P-1)) mod S directly.
  logic [PW-1:0]   vphase_q,     vphase_d;
  logic            done_seen_q,  done_seen_d;
  logic [N_PE-1:0] p_en_q,       p_en_d;
  logic            p_en_valid_q, p_en_valid_d;
  logic [N_PE-1:0] p_en_rmu_q,   p_en_rmu_d;
  logic            frame_done_q, frame_done_d;
  logic            cfg_err_q,    cfg_err_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic            cfg_legal;
  logic            row_active;
  logic            row_end;
  logic            frame_end;
  logic [N_PE-1:0] beat_mask;
  logic [NW-1:0]   walk_off;
  logic [NW-1:0]   next_off_adv;
  logic            lane_hit;
  logic            lane_in_row;

  always_comb begin
    cfg_legal = (cfg_patch_size != '0) &&
                (cfg_stride != '0) &&
                (cfg_stride <= cfg_patch_size) &&
                (32'(cfg_row_len)  >= 32'(cfg_patch_size)) &&
                (32'(cfg_num_rows) >= 32'(cfg_patch_size));
  end

  // Vertical gate: the row has a full patch above it and is on the row stride.
  always_comb begin
    row_active = (32'(row_q) >= (32'(p_q) - 32'd1)) && (vphase_q == '0);
    row_end    = (32'(col_base_q) + 32'(N_PE)) >= 32'(w_q);
    frame_end  = row_end && (32'(row_q) == (32'(h_q) - 32'd1));
  end

  // Horizontal walk: starting at next_off, every lane that equals the running
  // offset is a window-complete column, and the offset then steps by S. The
  // sequence is strictly increasing, so each hit is found at its own lane.
  // After the last lane the running offset is the first hit at or beyond the
  // beat, so subtracting N_PE gives the offset into the next beat. When
  // next_off already starts beyond the beat nothing hits and the same
  // subtraction applies, so both update cases share one expression.
  always_comb begin
    beat_mask   = '0;
    walk_off    = next_off_q;
    lane_hit    = 1'b0;
    lane_in_row = 1'b0;
    for (int i = 0; i < N_PE; i++) begin
      lane_hit     = (walk_off == NW'(i));
      lane_in_row  = (32'(col_base_q) + 32'(i)) < 32'(w_q);
      beat_mask[i] = row_active && lane_hit && lane_in_row;
      if (lane_hit) begin
        walk_off = walk_off + NW'(s_q);
      end
    end
    next_off_adv = walk_off - NW'(N_PE);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    s_d          = s_q;
    w_d          = w_q;
    h_d          = h_q;
    col_base_d   = col_base_q;
    row_d        = row_q;
    next_off_d   = next_off_q;
    vphase_d     = vphase_q;
    done_seen_d  = done_seen_q | done;
    p_en_d       = p_en_q;
    p_en_valid_d = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = cfg_err_q;
    // done_seen is registered, so the gate lands one cycle after done.
    p_en_rmu_d   = done_seen_q ? '0 : p_en_q;

    case (state_q)
      S_IDLE: begin
        // cycle_detect is ignored here, including in the start cycle.
        if (start) begin
          if (cfg_legal) begin
            p_d         = cfg_patch_size;
            s_d         = cfg_stride;
            w_d         = cfg_row_len;
            h_d         = cfg_num_rows;
            col_base_d  = '0;
            row_d       = '0;
            next_off_d  = NW'(cfg_patch_size) - NW'(1);
            vphase_d    = '0;
            // A done arriving in the start cycle still counts.
            done_seen_d = done;
            cfg_err_d   = 1'b0;
            state_d     = S_RUN;
          end else begin
            cfg_err_d   = 1'b1;
          end
        end
      end

      S_RUN: begin
        // start is ignored while running.
        if (cycle_detect) begin
          p_en_d       = beat_mask;
          p_en_valid_d = 1'b1;
          if (row_end) begin
            col_base_d = '0;
            next_off_d = NW'(p_q) - NW'(1);
            row_d      = row_q + RW'(1);
            // Phase only advances once rows have become window-complete.
            if (32'(row_q) >= (32'(p_q) - 32'd1)) begin
              vphase_d = ((vphase_q + PW'(1)) == s_q) ? '0 : (vphase_q + PW'(1));
            end else begin
              vphase_d = '0;
            end
            if (frame_end) begin
              frame_done_d = 1'b1;
              state_d      = S_IDLE;
            end
          end else begin
            col_base_d = col_base_q + CW'(N_PE);
            next_off_d = next_off_adv;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      p_q          <= '0;
      s_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_base_q   <= '0;
      row_q        <= '0;
      next_off_q   <= '0;
      vphase_q     <= '0;
      done_seen_q  <= 1'b0;
      p_en_q       <= '0;
      p_en_valid_q <= 1'b0;
      p_en_rmu_q   <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      s_q          <= s_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_base_q   <= col_base_d;
      row_q        <= row_d;
      next_off_q   <= next_off_d;
      vphase_q     <= vphase_d;
      done_seen_q  <= done_seen_d;
      p_en_q       <= p_en_d;
      p_en_valid_q <= p_en_valid_d;
      p_en_rmu_q   <= p_en_rmu_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign p_en       = p_en_q;
  assign p_en_valid = p_en_valid_q;
  assign p_en_rmu   = p_en_rmu_q;
  assign busy       = (state_q == S_RUN);
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule
